id_ex_reg: RTL

//  ID/EX pipeline register of the 5-stage RV32I core. Captures decoded operands and

---
 rtl/id_ex_reg_if.sv | 56 +++++
 rtl/id_ex_reg.sv | 88 ++++++++
 2 files changed

// File: rtl/id_ex_reg_if.sv
// ID/EX pipeline register bundle: pipeline control (stall/flush), the decoded
// ID-stage slot, and the registered EX-stage slot plus the bubble counter.
interface id_ex_reg_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic             stall;
    logic             flush;

    logic             id_valid;
    logic [XLEN-1:0]  id_pc;
    logic [XLEN-1:0]  id_rs1_data;
    logic [XLEN-1:0]  id_rs2_data;
    logic [XLEN-1:0]  id_imm;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic [4:0]       id_rd;
    logic [2:0]       id_funct3;
    logic [6:0]       id_funct7;
    logic [1:0]       id_ALUOp;
    logic [5:0]       id_ctrl;

    logic             ex_valid;
    logic [XLEN-1:0]  ex_pc;
    logic [XLEN-1:0]  ex_rs1_data;
    logic [XLEN-1:0]  ex_rs2_data;
    logic [XLEN-1:0]  ex_imm;
    logic [4:0]       ex_rs1;
    logic [4:0]       ex_rs2;
    logic [4:0]       ex_rd;
    logic [2:0]       ex_funct3;
    logic [6:0]       ex_funct7;
    logic [1:0]       ex_ALUOp;
    logic [5:0]       ex_ctrl;
    logic [CNT_W-1:0] bubble_cnt;

    // Pipeline-control / ID side: drives the slot, observes EX.
    modport master (
        output stall, flush,
        output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
        output id_rs1, id_rs2, id_rd, id_funct3, id_funct7, id_ALUOp, id_ctrl,
        input  ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
        input  ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7, ex_ALUOp, ex_ctrl,
        input  bubble_cnt
    );

    // Pipeline register side.
    modport slave (
        input  stall, flush,
        input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
        input  id_rs1, id_rs2, id_rd, id_funct3, id_funct7, id_ALUOp, id_ctrl,
        output ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
        output ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7, ex_ALUOp, ex_ctrl,
        output bubble_cnt
    );
endinterface

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register of the 5-stage RV32I core. One-cycle latency,
// flush > stall > load priority, invalid slots carry no control side effects,
// and a saturating count of inserted bubbles for hazard/perf debug.
module id_ex_reg #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    id_ex_reg_if.slave  pipe
);

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [1:0]      alu_op;
        logic [5:0]      ctrl;
    } slot_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    slot_t            slot_q, slot_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next-state selection: flush inserts a bubble, stall holds, otherwise load.
    always_comb begin
        // NOTE: defaults first so every path assigns every bit; no latches.
        slot_d = slot_q;
        cnt_d  = cnt_q;
        if (pipe.flush) begin
            // An all-zero slot is an invalid add with no writeback or memory effect.
            slot_d = '0;
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (!pipe.stall) begin
            slot_d.valid    = pipe.id_valid;
            slot_d.pc       = pipe.id_pc;
            slot_d.rs1_data = pipe.id_rs1_data;
            slot_d.rs2_data = pipe.id_rs2_data;
            slot_d.imm      = pipe.id_imm;
            slot_d.rs1      = pipe.id_rs1;
            slot_d.rs2      = pipe.id_rs2;
            slot_d.rd       = pipe.id_rd;
            slot_d.funct3   = pipe.id_funct3;
            slot_d.funct7   = pipe.id_funct7;
            slot_d.alu_op   = pipe.id_ALUOp;
            // An invalid slot must never branch, write memory or write the regfile.
            slot_d.ctrl     = pipe.id_valid ? pipe.id_ctrl : 6'b0;
        end
    end

    // State registers with asynchronous reset to the harmless empty slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_q <= '0;
            cnt_q  <= '0;
        end else begin
            // NOTE: non-blocking so all flops sample pre-edge values together.
            slot_q <= slot_d;
            cnt_q  <= cnt_d;
        end
    end

    // Outputs come straight from the flops.
    assign pipe.ex_valid    = slot_q.valid;
    assign pipe.ex_pc       = slot_q.pc;
    assign pipe.ex_rs1_data = slot_q.rs1_data;
    assign pipe.ex_rs2_data = slot_q.rs2_data;
    assign pipe.ex_imm      = slot_q.imm;
    assign pipe.ex_rs1      = slot_q.rs1;
    assign pipe.ex_rs2      = slot_q.rs2;
    assign pipe.ex_rd       = slot_q.rd;
    assign pipe.ex_funct3   = slot_q.funct3;
    assign pipe.ex_funct7   = slot_q.funct7;
    assign pipe.ex_ALUOp    = slot_q.alu_op;
    assign pipe.ex_ctrl     = slot_q.ctrl;
    assign pipe.bubble_cnt  = cnt_q;

endmodule
